// File: rtl/sequencia_pkg.sv
// Shared definitions for the sequence playback datapath: state codes and data/address widths.
package sequencia_pkg;

    localparam int unsigned LARGURA_DADO = 4;
    localparam int unsigned LARGURA_END  = 4;

    typedef enum logic [1:0] {
        ESPERA    = 2'd0,
        MOSTRA    = 2'd1,
        INTERVALO = 2'd2,
        FIM       = 2'd3
    } estado_t;

endpackage

// File: rtl/memoria_sequencia.sv
// 16x4 sequence storage: synchronous write, asynchronous read, contents survive reset.
module memoria_sequencia
    import sequencia_pkg::*;
(
    input  logic                    clock,
    input  logic                    we,
    input  logic [LARGURA_END-1:0]  end_escrita,
    input  logic [LARGURA_DADO-1:0] dado,
    input  logic [LARGURA_END-1:0]  end_leitura,
    output logic [LARGURA_DADO-1:0] saida
);

    logic [LARGURA_DADO-1:0] mem_q [2**LARGURA_END];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[end_escrita] <= dado;
        end
    end

    assign saida = mem_q[end_leitura];

endmodule

// File: rtl/gerador_sequencia.sv
// Sequence player: appends values to memory, then shows them on leds for T_ON cycles
// each with T_OFF blank cycles between, and pulses pronto after the last one.
module gerador_sequencia
    import sequencia_pkg::*;
#(
    parameter int unsigned N_MAX = 16,
    parameter int unsigned T_ON  = 4,
    parameter int unsigned T_OFF = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    limpa,
    input  logic                    carrega,
    input  logic [LARGURA_DADO-1:0] chaves,
    input  logic                    iniciar,
    output logic [LARGURA_DADO-1:0] leds,
    output logic                    led_valido,
    output logic                    pronto,
    output logic [4:0]              tamanho,
    output logic [2:0]              db_estado,
    output logic [LARGURA_END-1:0]  db_endereco
);

    localparam int unsigned TMax         = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int unsigned LarguraTimer = (TMax > 1) ? $clog2(TMax) : 1;
    localparam logic [LarguraTimer-1:0] TimerOnFim  = LarguraTimer'(T_ON - 1);
    localparam logic [LarguraTimer-1:0] TimerOffFim = LarguraTimer'(T_OFF - 1);
    localparam logic [4:0] TamanhoMax = 5'(N_MAX);

    estado_t                 estado_q, estado_d;
    logic [4:0]              tamanho_q, tamanho_d;
    logic [LARGURA_END-1:0]  endereco_q, endereco_d;
    logic [LarguraTimer-1:0] timer_q, timer_d;
    logic                    escreve;
    logic [LARGURA_DADO-1:0] dado_lido;

    memoria_sequencia u_memoria (
        .clock       (clock),
        .we          (escreve),
        .end_escrita (tamanho_q[LARGURA_END-1:0]),
        .dado        (chaves),
        .end_leitura (endereco_q),
        .saida       (dado_lido)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= ESPERA;
            tamanho_q  <= '0;
            endereco_q <= '0;
            timer_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            tamanho_q  <= tamanho_d;
            endereco_q <= endereco_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        tamanho_d  = tamanho_q;
        endereco_d = endereco_q;
        timer_d    = timer_q;
        escreve    = 1'b0;
        unique case (estado_q)
            ESPERA: begin
                // limpa beats iniciar beats carrega
                if (limpa) begin
                    tamanho_d = '0;
                end else if (iniciar) begin
                    if (tamanho_q != '0) begin
                        estado_d   = MOSTRA;
                        endereco_d = '0;
                        timer_d    = '0;
                    end else begin
                        estado_d = FIM;
                    end
                end else if (carrega && (tamanho_q < TamanhoMax)) begin
                    escreve   = 1'b1;
                    tamanho_d = tamanho_q + 5'd1;
                end
            end
            MOSTRA: begin
                if (timer_q == TimerOnFim) begin
                    timer_d = '0;
                    if ({1'b0, endereco_q} == (tamanho_q - 5'd1)) begin
                        estado_d = FIM;
                    end else begin
                        estado_d = INTERVALO;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            INTERVALO: begin
                if (timer_q == TimerOffFim) begin
                    timer_d    = '0;
                    endereco_d = endereco_q + 1'b1;
                    estado_d   = MOSTRA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FIM: begin
                estado_d = ESPERA;
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    assign leds        = (estado_q == MOSTRA) ? dado_lido : '0;
    assign led_valido  = (estado_q == MOSTRA);
    assign pronto      = (estado_q == FIM);
    assign tamanho     = tamanho_q;
    assign db_estado   = {1'b0, estado_q};
    assign db_endereco = endereco_q;

endmodule

// File: tb/tb_gerador_sequencia.sv
// Scoreboard bench for gerador_sequencia: each playback pushes its per-cycle expectations
// from a model of the stored sequence, and the scenario pops them one per clock.
module tb_gerador_sequencia;

    localparam int unsigned N_MAX = 16;
    localparam int unsigned T_ON  = 4;
    localparam int unsigned T_OFF = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       limpa, carrega, iniciar;
    logic [3:0] chaves;
    logic [3:0] leds;
    logic       led_valido, pronto;
    logic [4:0] tamanho;
    logic [2:0] db_estado;
    logic [3:0] db_endereco;

    typedef struct {
        logic [3:0] leds;
        logic       valido;
        logic       pronto;
        logic [2:0] estado;
        logic [3:0] endr;
    } exp_t;

    exp_t       sb[$];
    exp_t       e;
    logic [3:0] model_q[$];
    int         last_end = 0;
    int         checks   = 0;
    int         errors   = 0;
    int         idx;

    gerador_sequencia #(
        .N_MAX (N_MAX),
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .limpa       (limpa),
        .carrega     (carrega),
        .chaves      (chaves),
        .iniciar     (iniciar),
        .leds        (leds),
        .led_valido  (led_valido),
        .pronto      (pronto),
        .tamanho     (tamanho),
        .db_estado   (db_estado),
        .db_endereco (db_endereco)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic carrega_valor(input logic [3:0] v);
        carrega = 1'b1;
        chaves  = v;
        tick();
        carrega = 1'b0;
        if (model_q.size() < N_MAX) model_q.push_back(v);
    endtask

    task automatic limpa_seq();
        limpa = 1'b1;
        tick();
        limpa = 1'b0;
        model_q.delete();
    endtask

    task automatic dispara();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    // Expected per-cycle outputs from the cycle after iniciar through the ESPERA cycle after FIM.
    task automatic push_playback();
        exp_t x;
        int   n;
        n = model_q.size();
        for (int i = 0; i < n; i++) begin
            for (int t = 0; t < T_ON; t++) begin
                x = '{model_q[i], 1'b1, 1'b0, 3'd1, 4'(i)};
                sb.push_back(x);
            end
            if (i != n - 1) begin
                for (int t = 0; t < T_OFF; t++) begin
                    x = '{4'd0, 1'b0, 1'b0, 3'd2, 4'(i)};
                    sb.push_back(x);
                end
            end
        end
        if (n > 0) last_end = n - 1;
        x = '{4'd0, 1'b0, 1'b1, 3'd3, 4'(last_end)};
        sb.push_back(x);
        x = '{4'd0, 1'b0, 1'b0, 3'd0, 4'(last_end)};
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        limpa   = 1'b0;
        carrega = 1'b0;
        iniciar = 1'b0;
        chaves  = 4'd0;
        #12;
        checks++;
        if ({leds, led_valido, pronto, tamanho, db_estado, db_endereco} !== 17'd0) begin
            errors++;
            $display("FAIL reset: leds=%0d v=%0b p=%0b tam=%0d est=%0d end=%0d, required all 0",
                     leds, led_valido, pronto, tamanho, db_estado, db_endereco);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        checks++;
        if (tamanho !== 5'd0 || db_estado !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: tam=%0d est=%0d, required 0 0", tamanho, db_estado);
        end
    endtask

    task automatic test_load_play();
        logic [3:0] vals [3];
        vals = '{4'd3, 4'd7, 4'd12};
        for (int i = 0; i < 3; i++) begin
            carrega_valor(vals[i]);
            checks++;
            if (tamanho !== 5'(i + 1)) begin
                errors++;
                $display("FAIL load_tamanho[%0d]: got %0d required %0d", i, tamanho, i + 1);
            end
        end
        dispara();
        push_playback();
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({leds, led_valido, pronto, db_estado, db_endereco, tamanho} !==
                {e.leds, e.valido, e.pronto, e.estado, e.endr, 5'(model_q.size())}) begin
                errors++;
                $display("FAIL load_play[%0d]: got l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d required l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d",
                         idx, leds, led_valido, pronto, db_estado, db_endereco, tamanho,
                         e.leds, e.valido, e.pronto, e.estado, e.endr, model_q.size());
            end
            tick();
            idx++;
        end
        checks++;
        if (idx != 3 * T_ON + 2 * T_OFF + 2) begin
            errors++;
            $display("FAIL load_play_len: got %0d required %0d", idx, 3 * T_ON + 2 * T_OFF + 2);
        end
    endtask

    task automatic test_full_memory();
        limpa_seq();
        for (int i = 0; i < 17; i++) carrega_valor(4'(i));
        checks++;
        if (tamanho !== 5'd16) begin
            errors++;
            $display("FAIL full_tamanho: got %0d required 16", tamanho);
        end
        dispara();
        push_playback();
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({leds, led_valido, pronto, db_estado, db_endereco, tamanho} !==
                {e.leds, e.valido, e.pronto, e.estado, e.endr, 5'(model_q.size())}) begin
                errors++;
                $display("FAIL full_play[%0d]: got l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d required l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d",
                         idx, leds, led_valido, pronto, db_estado, db_endereco, tamanho,
                         e.leds, e.valido, e.pronto, e.estado, e.endr, model_q.size());
            end
            tick();
            idx++;
        end
    endtask

    task automatic test_empty();
        limpa_seq();
        dispara();
        push_playback();
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({leds, led_valido, pronto, db_estado, db_endereco, tamanho} !==
                {e.leds, e.valido, e.pronto, e.estado, e.endr, 5'(model_q.size())}) begin
                errors++;
                $display("FAIL empty[%0d]: got l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d required l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d",
                         idx, leds, led_valido, pronto, db_estado, db_endereco, tamanho,
                         e.leds, e.valido, e.pronto, e.estado, e.endr, model_q.size());
            end
            tick();
            idx++;
        end
    endtask

    task automatic test_simultaneous();
        limpa_seq();
        carrega_valor(4'd5);
        carrega_valor(4'd9);
        limpa   = 1'b1;
        iniciar = 1'b1;
        carrega = 1'b1;
        chaves  = 4'd1;
        tick();
        limpa   = 1'b0;
        iniciar = 1'b0;
        carrega = 1'b0;
        model_q.delete();
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (tamanho !== 5'd0 || db_estado !== 3'd0 || led_valido !== 1'b0) begin
                errors++;
                $display("FAIL all_three[%0d]: tam=%0d est=%0d v=%0b required 0 0 0",
                         c, tamanho, db_estado, led_valido);
            end
            tick();
        end
        carrega_valor(4'd5);
        carrega_valor(4'd9);
        iniciar = 1'b1;
        carrega = 1'b1;
        chaves  = 4'd15;
        tick();
        iniciar = 1'b0;
        carrega = 1'b0;
        push_playback();
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({leds, led_valido, pronto, db_estado, db_endereco, tamanho} !==
                {e.leds, e.valido, e.pronto, e.estado, e.endr, 5'(model_q.size())}) begin
                errors++;
                $display("FAIL start_and_load[%0d]: got l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d required l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d",
                         idx, leds, led_valido, pronto, db_estado, db_endereco, tamanho,
                         e.leds, e.valido, e.pronto, e.estado, e.endr, model_q.size());
            end
            tick();
            idx++;
        end
    endtask

    task automatic test_ignored();
        limpa_seq();
        carrega_valor(4'd1);
        carrega_valor(4'd2);
        carrega_valor(4'd3);
        dispara();
        push_playback();
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({leds, led_valido, pronto, db_estado, db_endereco, tamanho} !==
                {e.leds, e.valido, e.pronto, e.estado, e.endr, 5'(model_q.size())}) begin
                errors++;
                $display("FAIL ignored[%0d]: got l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d required l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d",
                         idx, leds, led_valido, pronto, db_estado, db_endereco, tamanho,
                         e.leds, e.valido, e.pronto, e.estado, e.endr, model_q.size());
            end
            if (idx == 1 || idx == 7) begin
                carrega = 1'b1;
                limpa   = (idx == 1);
                chaves  = 4'd15;
            end
            tick();
            carrega = 1'b0;
            limpa   = 1'b0;
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        limpa_seq();
        carrega_valor(4'd10);
        dispara();
        push_playback();
        push_playback();
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({leds, led_valido, pronto, db_estado, db_endereco, tamanho} !==
                {e.leds, e.valido, e.pronto, e.estado, e.endr, 5'(model_q.size())}) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d required l=%0d v=%0b p=%0b s=%0d a=%0d t=%0d",
                         idx, leds, led_valido, pronto, db_estado, db_endereco, tamanho,
                         e.leds, e.valido, e.pronto, e.estado, e.endr, model_q.size());
            end
            // first ESPERA cycle after FIM of the single-value playback
            if (idx == T_ON + 1) iniciar = 1'b1;
            tick();
            iniciar = 1'b0;
            idx++;
        end
    endtask

    task automatic test_reset_mid();
        limpa_seq();
        carrega_valor(4'd4);
        carrega_valor(4'd8);
        carrega_valor(4'd6);
        dispara();
        for (int c = 0; c < T_ON + T_OFF; c++) tick();
        checks++;
        if (leds !== 4'd8 || led_valido !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: leds=%0d v=%0b required 8 1", leds, led_valido);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({leds, led_valido, pronto, tamanho, db_estado} !== 13'd0) begin
            errors++;
            $display("FAIL mid_async: leds=%0d v=%0b p=%0b tam=%0d est=%0d required all 0",
                     leds, led_valido, pronto, tamanho, db_estado);
        end
        model_q.delete();
        last_end = 0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        dispara();
        checks++;
        if (pronto !== 1'b1 || db_estado !== 3'd3 || led_valido !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart: p=%0b est=%0d v=%0b required 1 3 0",
                     pronto, db_estado, led_valido);
        end
        tick();
        checks++;
        if (pronto !== 1'b0 || db_estado !== 3'd0) begin
            errors++;
            $display("FAIL mid_restart_end: p=%0b est=%0d required 0 0", pronto, db_estado);
        end
    endtask

    initial begin
        test_reset();
        test_load_play();
        test_full_memory();
        test_empty();
        test_simultaneous();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
